// File: rtl/req_arbiter_8_if.sv
// Request/grant bundle between eight requesters and the shared-resource arbiter.
//   req        requester i raises req[i] to ask for the resource
//   prio_mode  0 = round-robin, 1 = fixed priority (bit 7 highest)
//   gnt        one-hot grant, all zero when idle
//   gnt_id     binary index of the granted requester, 0 when idle
//   gnt_valid  high while a grant is active
interface req_arbiter_8_if;
    logic [7:0] req;
    logic       prio_mode;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    // requester side
    modport master (
        output req,
        output prio_mode,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    // arbiter side
    modport slave (
        input  req,
        input  prio_mode,
        output gnt,
        output gnt_id,
        output gnt_valid
    );
endinterface

// File: rtl/req_arbiter_8.sv
// Sequential 8-way arbiter for one shared downstream resource.
// Each decision picks a winner by fixed priority (bit 7 highest) or by
// round-robin starting just above the last winner. A grant is held while its
// owner keeps requesting, for at most MAX_HOLD consecutive cycles when another
// requester is waiting. All outputs are registered (one cycle latency).
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   slave side of req_arbiter_8_if (req, prio_mode in; gnt, gnt_id,
//         gnt_valid out)
module req_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    req_arbiter_8_if.slave bus
);
    localparam int unsigned CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic [2:0]    last_id, last_nxt;
    logic [2:0]    id_q, id_nxt;
    logic [7:0]    gnt_q, gnt_nxt;
    logic [7:0]    others;

    // Fixed: highest set bit. Round-robin: first set bit at offsets 1..8
    // above last; scanning offsets downward lets the nearest one win.
    function automatic logic [2:0] pick(input logic [7:0] m, input logic fixed,
                                        input logic [2:0] last);
        logic [2:0] w;
        logic [2:0] idx;
        w = '0;
        if (fixed) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (m[i]) w = 3'(i);
            end
        end else begin
            for (int unsigned k = 8; k >= 1; k--) begin
                idx = last + 3'(k);
                if (m[idx]) w = idx;
            end
        end
        return w;
    endfunction

    assign others = bus.req & ~(8'b1 << id_q);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last_id;
        id_nxt    = id_q;
        case (state)
            IDLE: begin
                id_nxt = '0;
                if (bus.req != '0) begin
                    state_nxt = GRANT;
                    id_nxt    = pick(bus.req, bus.prio_mode, last_id);
                    hold_nxt  = '0;
                    last_nxt  = id_nxt;
                end
            end
            GRANT: begin
                if (bus.req[id_q] && hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + 1'b1;
                end else if (!bus.req[id_q]) begin
                    if (bus.req != '0) begin
                        id_nxt   = pick(bus.req, bus.prio_mode, last_id);
                        hold_nxt = '0;
                        last_nxt = id_nxt;
                    end else begin
                        state_nxt = IDLE;
                        id_nxt    = '0;
                        hold_nxt  = '0;
                    end
                end else begin
                    // Hold limit reached: the owner is excluded unless nobody
                    // else wants the resource, in which case it is re-granted.
                    if (others != '0) begin
                        id_nxt = pick(others, bus.prio_mode, last_id);
                    end
                    hold_nxt = '0;
                    last_nxt = id_nxt;
                end
            end
            default: begin
                state_nxt = IDLE;
                id_nxt    = '0;
                hold_nxt  = '0;
            end
        endcase
        gnt_nxt = (state_nxt == GRANT) ? (8'b1 << id_nxt) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_id  <= 3'd7;
            id_q     <= '0;
            gnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            last_id  <= last_nxt;
            id_q     <= id_nxt;
            gnt_q    <= gnt_nxt;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = (state == GRANT);
endmodule

// File: tb/tb_req_arbiter_8.sv
// Self-checking bench for req_arbiter_8: random and directed request patterns,
// a cycle-level reference model feeding a scoreboard queue, and an
// independent monitor comparing DUT outputs against it.
module tb_req_arbiter_8;
    localparam int MAX_HOLD = 16;

    logic clk;
    logic rst;

    req_arbiter_8_if bus ();

    req_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state: who owns the resource and for how many cycles
    bit m_valid;
    int m_id;
    int m_held;
    int m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    function automatic int choose(input logic [7:0] m, input bit fixed, input int last);
        if (fixed) begin
            for (int i = 7; i >= 0; i--) if (m[i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) if (m[(last + k) % 8]) return (last + k) % 8;
        end
        return 0;
    endfunction

    // model: advance one clock using the arbitration rules, push expectation
    always @(posedge clk) begin
        if (!rst) begin
            logic [7:0] r;
            logic [7:0] mask;
            exp_t e;
            r = bus.req;
            if (!m_valid) begin
                if (r != 0) begin
                    m_valid = 1; m_id = choose(r, bus.prio_mode, m_last);
                    m_held = 1; m_last = m_id;
                end
            end else if (!r[m_id]) begin
                if (r != 0) begin
                    m_id = choose(r, bus.prio_mode, m_last); m_held = 1; m_last = m_id;
                end else begin
                    m_valid = 0; m_id = 0; m_held = 0;
                end
            end else if (m_held < MAX_HOLD) begin
                m_held++;
            end else begin
                mask = r;
                mask[m_id] = 1'b0;
                if (mask != 0) m_id = choose(mask, bus.prio_mode, m_last);
                m_held = 1; m_last = m_id;
            end
            e.valid = m_valid;
            e.id    = 3'(m_id);
            e.gnt   = m_valid ? (8'b1 << m_id) : 8'h00;
            exp_q.push_back(e);
        end
    end

    // monitor: compare outputs shortly after every active edge
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_gnt", bus.gnt, e.gnt);
                chk("sb_gnt_id", bus.gnt_id, e.id);
                chk("sb_gnt_valid", bus.gnt_valid, e.valid);
            end
            chk("onehot", $onehot0(bus.gnt), 1);
        end
    end

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_held = 0; m_last = 7;
    endtask

    // reset pulse between edges; outputs must clear without a clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_gnt", bus.gnt, 8'h00);
        chk("rst_gnt_id", bus.gnt_id, 3'd0);
        chk("rst_gnt_valid", bus.gnt_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic [2:0] seq [4];
        rst = 1'b1;
        bus.req = '0;
        bus.prio_mode = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // reset while a grant is active
        bus.req = 8'h04;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", bus.gnt_valid, 1'b1);
        do_reset();

        // fixed priority, back-to-back handover
        bus.prio_mode = 1'b1;
        bus.req = 8'h29;
        @(negedge clk);
        chk("fix_gnt", bus.gnt, 8'h20);
        chk("fix_id", bus.gnt_id, 3'd5);
        bus.req = 8'h09;
        @(negedge clk);
        chk("b2b_gnt", bus.gnt, 8'h08);
        chk("b2b_id", bus.gnt_id, 3'd3);
        bus.req = '0;
        @(negedge clk);
        chk("release_valid", bus.gnt_valid, 1'b0);
        @(negedge clk);
        chk("idle_gnt", bus.gnt, 8'h00);
        do_reset();

        // round-robin alternation, winner releases after one cycle
        bus.prio_mode = 1'b0;
        bus.req = 8'h81;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq[i] = bus.gnt_id;
            bus.req = 8'h81 & ~bus.gnt;
        end
        chk("rr_order", {seq[0], seq[1], seq[2], seq[3]}, {3'd0, 3'd7, 3'd0, 3'd7});
        bus.req = '0;
        @(negedge clk);
        do_reset();

        // wrap-around search from last_id=6
        bus.req = 8'h40;
        @(negedge clk);
        chk("wrap_pre", bus.gnt_id, 3'd6);
        bus.req = 8'h03;
        @(negedge clk);
        chk("wrap_id", bus.gnt_id, 3'd0);
        bus.req = '0;
        @(negedge clk);
        do_reset();

        // hold limit with a waiting requester, then sole-requester re-grant
        bus.req = 8'h24;
        n = 0;
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            if (bus.gnt_id == 3'd2 && bus.gnt_valid) n++;
        end
        chk("hold_len", n, MAX_HOLD);
        @(negedge clk);
        chk("hold_switch", bus.gnt_id, 3'd5);
        bus.req = 8'h04;
        n = 0;
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            @(negedge clk);
            if (bus.gnt == 8'h04 && bus.gnt_valid) n++;
        end
        chk("sole_hold", n, 3 * MAX_HOLD);
        bus.req = '0;
        @(negedge clk);
        chk("drop_valid", bus.gnt_valid, 1'b0);
        do_reset();

        // random traffic with long holds, releases and mode flips
        for (int c = 0; c < 2000; c++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 15));
            if (r == 0) bus.req = 8'($urandom);
            else if (r == 1) bus.req = bus.req & ~bus.gnt;
            else if (r == 2) bus.req = bus.req | 8'(1 << $urandom_range(0, 7));
            else if (r == 3 && $urandom_range(0, 3) == 0) bus.req = '0;
            if ($urandom_range(0, 31) == 0) bus.prio_mode = ~bus.prio_mode;
            if (c == 1000) do_reset();
        end
        bus.req = '0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
